// File: rtl/axi_lite_ipif_register_bank.sv
// AXI4-Lite slave register bank for the bus side of the IPIF clock-converter path.
// Writes land in params_from_bus and pulse WrCE_from_bus; reads return a snapshot
// of params_to_bus and pulse RdCE_from_bus. Write and read channels are independent.
module axi_lite_ipif_register_bank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int N_REG = 2,
  parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] PARAM_RESET = '0
) (
  input  logic                                bus_clk,
  input  logic                                bus_clk_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic [N_REG-1:0]                    WrCE_from_bus,
  output logic [N_REG-1:0]                    RdCE_from_bus,
  output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_from_bus,
  input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_to_bus
);

  localparam int W        = C_S_AXI_DATA_WIDTH;
  localparam int NB       = W / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int IDX_W    = (N_REG > 1) ? $clog2(N_REG) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // write channel state
  w_state_t          r_wstate;
  logic              r_aw_full;
  logic [IDX_W-1:0]  r_aw_idx;
  logic              r_w_full;
  logic [W-1:0]      r_wdata;
  logic [NB-1:0]     r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic [N_REG-1:0]  r_wrce;
  logic [W-1:0]      r_params [N_REG];

  // read channel state
  r_state_t          r_rstate;
  logic              r_rvalid;
  logic [W-1:0]      r_rdata;
  logic [1:0]        r_rresp;
  logic [N_REG-1:0]  r_rdce;

  logic              w_aw_fire;
  logic              w_w_fire;
  logic              w_commit;
  logic [IDX_W-1:0]  w_cm_idx;
  logic [IDX_W-1:0]  w_ar_idx;
  logic [W-1:0]      w_cm_data;
  logic [NB-1:0]     w_cm_strb;
  logic [N_REG-1:0]  w_wr_hit;
  logic [N_REG-1:0]  w_rd_hit;
  logic [W-1:0]      w_rd_sel;
  logic              w_unused;

  // Address bits outside the register index are deliberately ignored.
  assign w_unused = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  // READYs are held low while reset is asserted, high in idle with a free slot.
  assign S_AXI_AWREADY = ~bus_clk_areset & (r_wstate == W_IDLE) & ~r_aw_full;
  assign S_AXI_WREADY  = ~bus_clk_areset & (r_wstate == W_IDLE) & ~r_w_full;
  assign S_AXI_ARREADY = ~bus_clk_areset & (r_rstate == R_IDLE);

  assign w_aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_fire  = S_AXI_WVALID & S_AXI_WREADY;

  // A beat arriving on the commit edge is used directly, bypassing its slot.
  assign w_cm_idx  = r_aw_full ? r_aw_idx : S_AXI_AWADDR[ADDR_LSB +: IDX_W];
  assign w_cm_data = r_w_full ? r_wdata : S_AXI_WDATA;
  assign w_cm_strb = r_w_full ? r_wstrb : S_AXI_WSTRB;
  assign w_commit  = (r_wstate == W_IDLE) & (r_aw_full | w_aw_fire) & (r_w_full | w_w_fire);
  assign w_ar_idx  = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

  // One-hot decode; an index with no matching register leaves the hit vector empty.
  for (genvar gi = 0; gi < N_REG; gi++) begin : g_reg
    assign w_wr_hit[gi] = (w_cm_idx == IDX_W'(gi));
    assign w_rd_hit[gi] = (w_ar_idx == IDX_W'(gi));
    assign params_from_bus[gi*W +: W] = r_params[gi];
  end

  // Read mux over the IP-side values; zero when out of range.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (w_rd_hit[i]) w_rd_sel = params_to_bus[i*W +: W];
    end
  end

  // Write FSM: collect AW and W in slots, commit when both present, hold B until accepted.
  always_ff @(posedge bus_clk or posedge bus_clk_areset) begin
    if (bus_clk_areset) begin
      r_wstate  <= W_IDLE;
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_wrce    <= '0;
    end else begin
      r_wrce <= '0;
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_fire) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
          end
          if (w_w_fire) begin
            r_w_full <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
          end
          if (w_commit) begin
            r_wstate <= W_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= (|w_wr_hit) ? RESP_OKAY : RESP_SLVERR;
            r_wrce   <= w_wr_hit;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Register file: byte-lane merge of the committed write into the addressed register.
  always_ff @(posedge bus_clk or posedge bus_clk_areset) begin
    if (bus_clk_areset) begin
      for (int i = 0; i < N_REG; i++) r_params[i] <= PARAM_RESET[i*W +: W];
    end else if (w_commit) begin
      for (int i = 0; i < N_REG; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (w_wr_hit[i] && w_cm_strb[b]) r_params[i][b*8 +: 8] <= w_cm_data[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM: snapshot the selected value on AR, hold R until accepted.
  always_ff @(posedge bus_clk or posedge bus_clk_areset) begin
    if (bus_clk_areset) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_rdce   <= '0;
    end else begin
      r_rdce <= '0;
      case (r_rstate)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            r_rstate <= R_DATA;
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_sel;
            r_rresp  <= (|w_rd_hit) ? RESP_OKAY : RESP_SLVERR;
            r_rdce   <= w_rd_hit;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign WrCE_from_bus = r_wrce;
  assign RdCE_from_bus = r_rdce;

endmodule
